uart_rx_byte: RTL
=================

// Module: uart_rx_byte
// PURPOSE
//   Asynchronous serial receiver for the board's Uart_Rx pin: 8 data bits, no parity, 1 stop bit, LSB first.
//   Sits directly upstream of the Top-level command/display logic.
//   Delivers each received byte as a one-cycle valid strobe, with framing-error and busy flags.
//   Mid-bit sampling is derived from a clock-divider counter; no external baud tick is needed.
// PARAMETERS
//   CLK_FREQ   50_000_000  system clock frequency, Hz
//   BAUD       9600        line rate, bit/s
//   CLKS_PER_BIT is a localparam = CLK_FREQ/BAUD (integer division; must be >= 4).
//   CNT_W is a localparam = $clog2(CLKS_PER_BIT).
// PORTS
//   sys_clk       in   1  system clock, rising edge
//   sys_rst       in   1  asynchronous, active-high reset
//   Uart_Rx       in   1  raw serial line, idle high, asynchronous to sys_clk
//   rx_data       out  8  last correctly framed byte; held until the next valid byte
//   rx_valid      out  1  1-cycle pulse; rx_data is new in the same cycle
//   rx_frame_err  out  1  1-cycle pulse when the stop bit samples low
//   rx_busy       out  1  high from start-bit detect until return to IDLE
// BEHAVIOUR
//   Reset: rx_data=8'h00, rx_valid=0, rx_frame_err=0, rx_busy=0, state=IDLE.
//     Synchronizer flops reset to 1 (line idle), so reset release never fakes a start bit.
//   Input path: Uart_Rx passes through a 2-FF synchronizer (rx_s). All decisions use rx_s only.
//   Bit counter cnt (CNT_W bits) clears on every state entry. bit_idx (3 bits) counts data bits.
//   FSM states:
//     IDLE  - rx_busy=0. rx_s==0 -> START; cnt=0.
//     START - at cnt==CLKS_PER_BIT/2-1, sample rx_s:
//               0 -> DATA (bit_idx=0, cnt=0).
//               1 -> glitch: IDLE, no strobe.
//     DATA  - at cnt==CLKS_PER_BIT-1: shift rx_s into shreg[7] (LSB first, right shift); cnt=0.
//               bit_idx==7 -> STOP, else bit_idx+1.
//     STOP  - at cnt==CLKS_PER_BIT-1, sample rx_s:
//               1 -> rx_data<=shreg, rx_valid=1 for one cycle, -> IDLE.
//               0 -> rx_frame_err=1 for one cycle, rx_data unchanged, -> BREAK.
//     BREAK - wait until rx_s==1 (line released), then -> IDLE. A held-low line (break) gives exactly one error.
//   Strobe timing: rx_valid/rx_frame_err assert mid-stop-bit, about 9.5 bit times after the falling start edge,
//     plus 2 cycles of synchronizer latency.
//   Back-to-back frames: a start edge arriving right after the stop-bit sample is accepted with no lost frame.
//     IDLE is entered at the stop-bit mid-point.
//   rx_valid and rx_frame_err are mutually exclusive and never assert in consecutive cycles for one frame.
//   rx_busy = (state != IDLE), registered.
//   Reset mid-frame: immediate return to IDLE, partial byte discarded, no strobe.
//     Reception resumes at the next falling edge after reset release.
//   No receive buffer: the consumer must capture rx_data before the next byte.
//     Overrun is silent; rx_data is overwritten.
// TESTING
//   Benches use CLK_FREQ=1_000_000, BAUD=100_000 (10 clk/bit) unless noted.
//   1. Send 8'hA5 with a correct stop bit.
//      -> exactly one rx_valid pulse, rx_data=8'hA5, rx_frame_err never high.
//   2. Send 8'h00, then 8'hFF back-to-back with no idle gap.
//      -> two rx_valid pulses ~100 clk apart, data 00 then FF.
//   3. 3-clk low glitch on an idle line.
//      -> no strobe; rx_busy pulses, back to 0 within 7 clk of the glitch end.
//   4. Send 8'h3C with stop bit forced low, line held low 30 clk, then high.
//      -> one rx_frame_err pulse; rx_data keeps its previous value; rx_busy drops after the line goes high.
//   5. Assert sys_rst during bit 4 of a frame, release, then send 8'h81.
//      -> all outputs 0 during reset; next strobe is rx_valid with rx_data=8'h81.
//   6. Default params, send 8'h5A at a rate 2% off nominal 9600.
//      -> rx_valid with rx_data=8'h5A.

Source files
------------

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
//   8N1 asynchronous serial receiver (LSB first) for the board's Uart_Rx pin.
//   Bit timing comes from an internal clock-divider counter; data bits and the
//   stop bit are sampled at their mid-points.
//
//   Ports
//     sys_clk      in   system clock, rising edge
//     sys_rst      in   asynchronous active-high reset
//     Uart_Rx      in   raw serial line, idle high, asynchronous to sys_clk
//     rx_data      out  last correctly framed byte, held until the next one
//     rx_valid     out  one-cycle strobe, rx_data is new in the same cycle
//     rx_frame_err out  one-cycle strobe when the stop bit samples low
//     rx_busy      out  high from start-bit detect until back in IDLE
// -----------------------------------------------------------------------------
module uart_rx_byte #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       Uart_Rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  // CLKS_PER_BIT must be at least 4 for the half-bit count to be meaningful.
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             rx_m, rx_s;

  // 2-FF synchronizer. Resets to the idle level so that reset release can
  // never look like a falling start edge.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= Uart_Rx;
      rx_s <= rx_m;
    end
  end

  // Receiver FSM. rx_busy is updated together with every state change so it
  // always equals (state != IDLE) without a separate decode stage.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          // Re-check the line half a bit in; a short low pulse is a glitch.
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // IDLE is re-entered at the stop-bit mid-point so a following start
          // edge right after the stop bit is not missed.
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              state    <= IDLE;
              rx_busy  <= 1'b0;
            end else begin
              rx_frame_err <= 1'b1;
              state        <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          // Held-low line: stay here so a break yields exactly one error.
          cnt <= '0;
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
